// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin arbiter sharing one combinational ALU between two
//            valid/ready requesters, with a registered, id-tagged response.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [7:0]  req0_x_i,
  input  logic [7:0]  req0_y_i,
  input  logic [1:0]  req0_m_i,
  input  logic [1:0]  req0_s_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [7:0]  req1_x_i,
  input  logic [7:0]  req1_y_i,
  input  logic [1:0]  req1_m_i,
  input  logic [1:0]  req1_s_i,
  output logic [7:0]  alu_x_o,
  output logic [7:0]  alu_y_o,
  output logic [1:0]  alu_m_o,
  output logic [1:0]  alu_s_o,
  input  logic [15:0] alu_z_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [15:0] rsp_z_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_q;
  logic [7:0]  alu_x_q;
  logic [7:0]  alu_y_q;
  logic [1:0]  alu_m_q;
  logic [1:0]  alu_s_q;
  logic [15:0] rsp_z_q;
  logic        rsp_id_q;
  logic        rsp_valid_q;

  logic        grant_id;
  logic        accept;
  logic [7:0]  sel_x;
  logic [7:0]  sel_y;
  logic [1:0]  sel_m;
  logic [1:0]  sel_s;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_id = req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      grant_id = ~last_q;
    end
  end

  assign req0_ready_o = rst_ni && (state_q == IDLE) && req0_valid_i && !grant_id;
  assign req1_ready_o = rst_ni && (state_q == IDLE) && req1_valid_i &&  grant_id;
  assign accept       = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);

  always_comb begin
    sel_x = req0_x_i;
    sel_y = req0_y_i;
    sel_m = req0_m_i;
    sel_s = req0_s_i;
    if (grant_id) begin
      sel_x = req1_x_i;
      sel_y = req1_y_i;
      sel_m = req1_m_i;
      sel_s = req1_s_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      alu_x_q     <= 8'd0;
      alu_y_q     <= 8'd0;
      alu_m_q     <= 2'd0;
      alu_s_q     <= 2'd0;
      rsp_z_q     <= 16'd0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_x_q  <= sel_x;
            alu_y_q  <= sel_y;
            alu_m_q  <= sel_m;
            alu_s_q  <= sel_s;
            rsp_id_q <= grant_id;
            last_q   <= grant_id;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs have settled for a full cycle; capture its result.
          rsp_z_q     <= alu_z_i;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign alu_x_o     = alu_x_q;
  assign alu_y_o     = alu_y_q;
  assign alu_m_o     = alu_m_q;
  assign alu_s_o     = alu_s_q;
  assign rsp_z_o     = rsp_z_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_valid_o = rsp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter: directed table, corner
//            sequences and a randomized run against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_x, req0_y, req1_x, req1_y;
  logic [1:0]  req0_m, req0_s, req1_m, req1_s;
  logic [7:0]  alu_x, alu_y;
  logic [1:0]  alu_m, alu_s;
  logic [15:0] alu_z;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_z;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  alu_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_x_i(req0_x), .req0_y_i(req0_y), .req0_m_i(req0_m), .req0_s_i(req0_s),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_x_i(req1_x), .req1_y_i(req1_y), .req1_m_i(req1_m), .req1_s_i(req1_s),
    .alu_x_o(alu_x), .alu_y_o(alu_y), .alu_m_o(alu_m), .alu_s_o(alu_s),
    .alu_z_i(alu_z),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_z_o(rsp_z)
  );

  assign alu_z = {alu_x, alu_y};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        v0;
    logic        v1;
    logic [7:0]  x0;
    logic [7:0]  y0;
    logic [1:0]  m0;
    logic [1:0]  s0;
    logic [7:0]  x1;
    logic [7:0]  y1;
    logic [1:0]  m1;
    logic [1:0]  s1;
    logic        exp_id;
    logic [15:0] exp_z;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One isolated operation from idle; expects accept in the first cycle.
  task automatic do_op(input vec_t v);
    logic [19:0] exp_ops;
    req0_valid = v.v0; req0_x = v.x0; req0_y = v.y0; req0_m = v.m0; req0_s = v.s0;
    req1_valid = v.v1; req1_x = v.x1; req1_y = v.y1; req1_m = v.m1; req1_s = v.s1;
    rsp_ready  = 1'b1;
    exp_ops = v.exp_id ? {v.x1, v.y1, v.m1, v.s1} : {v.x0, v.y0, v.m0, v.s0};
    @(negedge clk);
    chk("op_grant", {req1_ready, req0_ready}, v.exp_id ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("op_alu_regs", {alu_x, alu_y, alu_m, alu_s}, exp_ops);
    @(negedge clk);
    chk("op_exec_no_valid", rsp_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("op_rsp", {rsp_valid, rsp_id, rsp_z}, {1'b1, v.exp_id, v.exp_z});
    @(posedge clk); #1;
    chk("op_rsp_done", rsp_valid, 1'b0);
  endtask

  // Continuous stream with rsp_ready held high; collects 4 accepts/responses.
  task automatic stream(input bit use0, input bit use1, input bit vary);
    int ac [4];
    logic [15:0] rz [4];
    logic rid [4];
    int nacc = 0;
    int nrsp = 0;
    int k1 = 0;
    bit a0, a1;
    logic exp_id;
    logic [7:0] ex, ey;
    req0_x = 8'hA0; req0_y = 8'h01; req0_m = 2'd0; req0_s = 2'd0;
    req1_x = vary ? 8'h40 : 8'hB0; req1_y = vary ? 8'h90 : 8'h02;
    req1_m = 2'd1; req1_s = 2'd2;
    rsp_ready  = 1'b1;
    req0_valid = use0;
    req1_valid = use1;
    for (int t = 0; t < 40 && nrsp < 4; t++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (rsp_valid && nrsp < 4) begin
        rz[nrsp] = rsp_z;
        rid[nrsp] = rsp_id;
        nrsp++;
      end
      @(posedge clk); #1;
      if ((a0 || a1) && nacc < 4) begin
        ac[nacc] = cyc;
        nacc++;
        if (a1 && vary) begin
          k1++;
          req1_x = 8'h40 + 8'(k1);
          req1_y = 8'h90 + 8'(k1);
        end
        if (nacc == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("stream_accepts", nacc, 4);
    chk("stream_responses", nrsp, 4);
    if (nacc == 4)
      for (int i = 1; i < 4; i++) chk("stream_spacing", ac[i] - ac[i-1], 3);
    for (int i = 0; i < nrsp; i++) begin
      exp_id = (use0 && use1) ? 1'(i % 2) : 1'(use1);
      ex = 8'h40 + 8'(i);
      ey = 8'h90 + 8'(i);
      chk("stream_id", rid[i], exp_id);
      chk("stream_z", rz[i], vary ? {ex, ey} : (exp_id ? 16'hB002 : 16'hA001));
    end
  endtask

  task automatic random_run(input int ncyc);
    bit m_busy = 1'b0;
    int m_age = 0;
    bit m_last = 1'b1;
    bit m_id = 1'b0;
    logic [15:0] m_z = 16'd0;
    logic [3:0] m_ms = 4'd0;
    bit g, er0, er1, erv, acc0, acc1, done;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      // Reference: an operation is outstanding from accept until its response
      // handshake; the response is presentable from the second cycle on.
      g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
      er0 = !m_busy && req0_valid && !g;
      er1 = !m_busy && req1_valid && g;
      erv = m_busy && (m_age >= 1);
      chk("rnd_ready0", req0_ready, er0);
      chk("rnd_ready1", req1_ready, er1);
      chk("rnd_rsp_valid", rsp_valid, erv);
      if (erv) chk("rnd_rsp", {rsp_id, rsp_z}, {m_id, m_z});
      if (m_busy) chk("rnd_alu_regs", {alu_x, alu_y, alu_m, alu_s}, {m_z, m_ms});
      acc0 = er0;
      acc1 = er1;
      done = erv && rsp_ready;
      @(posedge clk); #1;
      if (acc0 || acc1) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_id   = acc1;
        m_last = acc1;
        m_z    = acc1 ? {req1_x, req1_y} : {req0_x, req0_y};
        m_ms   = acc1 ? {req1_m, req1_s} : {req0_m, req0_s};
      end else if (m_busy) begin
        if (done) m_busy = 1'b0;
        else m_age++;
      end
      if (!(req0_valid && !acc0)) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_x = 8'($urandom); req0_y = 8'($urandom);
        req0_m = 2'($urandom); req0_s = 2'($urandom);
      end
      if (!(req1_valid && !acc1)) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_x = 8'($urandom); req1_y = 8'($urandom);
        req1_m = 2'($urandom); req1_s = 2'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h12, 8'h34, 2'd2, 2'd1, 8'h00, 8'h00, 2'd0, 2'd0, 1'b0, 16'h1234};
    vecs[1] = '{1'b1, 1'b1, 8'hA0, 8'h01, 2'd0, 2'd0, 8'hB0, 8'h02, 2'd1, 2'd3, 1'b1, 16'hB002};
    vecs[2] = '{1'b1, 1'b1, 8'hA0, 8'h01, 2'd3, 2'd2, 8'hB0, 8'h02, 2'd1, 2'd0, 1'b0, 16'hA001};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 2'd0, 2'd0, 8'hC3, 8'h5A, 2'd1, 2'd3, 1'b1, 16'hC35A};
    vecs[4] = '{1'b1, 1'b0, 8'h7E, 8'h81, 2'd2, 2'd2, 8'h00, 8'h00, 2'd0, 2'd0, 1'b0, 16'h7E81};
    vecs[5] = '{1'b1, 1'b1, 8'h11, 8'h22, 2'd1, 2'd1, 8'h33, 8'h44, 2'd2, 2'd3, 1'b1, 16'h3344};
    vecs[6] = '{1'b1, 1'b1, 8'hFF, 8'h00, 2'd3, 2'd3, 8'h00, 8'hFF, 2'd0, 2'd1, 1'b0, 16'hFF00};

    // Reset with both requesters asserting.
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 8'h5C; req0_y = 8'h3D; req0_m = 2'd3; req0_s = 2'd3;
    req1_valid = 1'b1; req1_x = 8'h6E; req1_y = 8'h7F; req1_m = 2'd2; req1_s = 2'd1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {req1_ready, req0_ready}, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_alu", {alu_x, alu_y, alu_m, alu_s}, 20'd0);
    chk("reset_rsp_z", rsp_z, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

    for (int i = 0; i < 7; i++) do_op(vecs[i]);

    // Backpressure: five stalled RESP cycles with both requesters waiting.
    req0_valid = 1'b1; req0_x = 8'h55; req0_y = 8'hAA; req0_m = 2'd3; req0_s = 2'd0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_x = 8'h01; req0_y = 8'h02;
    req1_valid = 1'b1; req1_x = 8'h03; req1_y = 8'h04;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_z}, {1'b1, 1'b0, 16'h55AA});
      chk("bp_ready_low", {req1_ready, req0_ready}, 2'b00);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_final", {rsp_valid, rsp_z}, {1'b1, 16'h55AA});
    @(posedge clk); #1;
    chk("bp_done", rsp_valid, 1'b0);

    // Reset while a req1 response is pending.
    req1_valid = 1'b1; req1_x = 8'hDE; req1_y = 8'hAD; rsp_ready = 1'b0;
    @(negedge clk);
    chk("mr_grant1", {req1_ready, req0_ready}, 2'b10);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_x = 8'h21; req0_y = 8'h43; req0_m = 2'd0; req0_s = 2'd0;
    req1_valid = 1'b1; req1_x = 8'h65; req1_y = 8'h87;
    @(negedge clk);
    chk("mr_ready_in_rst_a", {req1_ready, req0_ready}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_ready_in_rst_b", {req1_ready, req0_ready}, 2'b00);
    chk("mr_no_rsp", rsp_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("mr_tie_req0", {req1_ready, req0_ready}, 2'b01);
    chk("mr_no_rsp2", rsp_valid, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_next_rsp", {rsp_valid, rsp_id, rsp_z}, {1'b1, 1'b0, 16'h2143});
    @(posedge clk); #1;

    do_reset();
    stream(1'b1, 1'b1, 1'b0);
    do_reset();
    stream(1'b0, 1'b1, 1'b1);

    do_reset();
    random_run(400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational `alu` between two requesters. Each requester uses a valid/ready handshake. The block arbitrates round-robin and registers the winning operands onto the ALU inputs. It captures the 16-bit ALU result one cycle later and returns it, tagged with the requester id, on a valid/ready response channel. It sits between the requesting masters and the `alu` instance, and is the only driver of the ALU's `x`, `y`, `m` and `s` inputs.

## Interface
No parameters. Requester count is fixed at 2 and widths match `alu`.

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_x, req0_y  in  8 each  requester 0 operands
- req0_m  in  2  requester 0 mode
- req0_s  in  2  requester 0 unit select
- req1_valid, req1_ready, req1_x, req1_y, req1_m, req1_s  same as requester 0, for requester 1
- alu_x, alu_y  out  8 each  registered operands to the ALU
- alu_m, alu_s  out  2 each  registered mode and select to the ALU
- alu_z  in  16  ALU result (combinational from alu_*)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_z  out  16  registered result

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant logic is combinational from the valid lines and the pointer `last` (1 bit). The grant goes to the only valid requester.
  - If both are valid, the grant goes to the requester ≠ `last`.
  - `reqN_ready` = 1 only for the granted requester, and only in IDLE.
  - On `valid & ready`: latch x/y/m/s into `alu_*`, latch the id into `rsp_id`, set `last` = id, go to EXEC.
  - With no valid request, stay in IDLE and hold all registers.
- EXEC: latch `rsp_z <= alu_z`, then go to RESP. Both ready outputs are 0.
- RESP: `rsp_valid` = 1. Hold `rsp_z` and `rsp_id` stable until `rsp_ready` = 1, then go to IDLE. Both ready outputs are 0.
- `alu_*` registers hold their last value outside the accept cycle; they are not cleared after use.
- Requester rules: while `valid` = 1 and `ready` = 0, the payload must stay stable and `valid` must not drop. This is not checked.
- Arithmetic: no width conversion. `rsp_z` equals `alu_z` bit-for-bit.
- Reset values (rst_n = 0 at a clock edge):
  - state = IDLE, `last` = 1, so requester 0 wins the first tie;
  - `alu_x`, `alu_y`, `alu_m`, `alu_s`, `rsp_z`, `rsp_id` = 0;
  - `rsp_valid` = 0;
  - `req0_ready` and `req1_ready` are forced to 0 while rst_n = 0.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped and no response is issued. The first tie after reset goes to requester 0.

## Timing
- Accept at edge T (IDLE, handshake).
  - The `alu_*` registers update at T.
  - `rsp_z` is captured at T+1 (EXEC).
  - `rsp_valid` = 1 from after T+1, during the cycle ending at edge T+2.
- Minimum spacing between accepts is 3 cycles, when `rsp_ready` is held at 1.
- `rsp_ready` = 1 in the first RESP cycle completes the response at that edge. The next accept can occur at the following edge.
- A `rsp_ready` stall of k cycles adds k cycles to the accept spacing.
- `rsp_valid` never drops without a handshake except on reset.
- `reqN_ready` is combinational. It depends on state, `last`, and both valids; it has no path from `rsp_ready`.

## Test plan
The bench ALU model returns `alu_z = {alu_x, alu_y}`.

- **Reset:** hold rst_n = 0 for 2 cycles with both valids = 1 → `rsp_valid` = 0, both ready = 0, `alu_*` = 0, `rsp_z` = 0.
- **Single request:** req0 x = 8'h12, y = 8'h34, m = 2, s = 1, with `rsp_ready` = 1.
  - `req0_ready` = 1 in the same cycle.
  - `alu_s` = 1 and `alu_m` = 2 after the accept edge.
  - 2 cycles after accept: `rsp_valid` = 1, `rsp_z` = 16'h1234, `rsp_id` = 0.
- **Tie fairness:** both valid continuously.
  - req0 uses x = 8'hA0, y = 8'h01; req1 uses x = 8'hB0, y = 8'h02.
  - Responses alternate id 0, 1, 0, 1 with `rsp_z` = 16'hA001, 16'hB002, and so on.
  - Accepts are exactly 3 cycles apart.
- **Backpressure:** `rsp_ready` = 0 for 5 cycles in RESP.
  - `rsp_valid`, `rsp_z` and `rsp_id` stay stable.
  - Both ready = 0 throughout.
  - The response completes on the first cycle `rsp_ready` = 1.
- **Reset mid-RESP:** accept from req1, then assert rst_n = 0 during RESP.
  - No response is ever presented for that operation.
  - After release with both valid, req0 is granted first.
- **Lone requester:** only req1 valid for 4 operations → all 4 are granted to req1, with no idle bubble beyond the 3-cycle spacing.
